shift_exec_pipe: RTL and testbench
==================================

Name: shift_exec_pipe

Overview:
- Two-stage pipelined shift/rotate execute unit for the 16-bit datapath.
- Sits between decode/operand read and writeback. Accepts a shift micro-op under a valid/ready handshake and translates the opcode into the 2-bit op / 4-bit count pair consumed by barrelShifter.
- Registers the operands before the shifter and the result after it, and returns the result with its destination tag.

Parameters:
- N, 16, data width; must match barrelShifter N.
- C, 4, shift-count width; must match barrelShifter C.
- T, 3, destination-register tag width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream micro-op present.
- in_ready  output  1  stage A can accept this cycle.
- in_opc  input  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA; 101-111 illegal.
- in_data  input  N  operand to shift.
- in_cnt  input  C  shift amount, 0..15.
- in_tag  input  T  destination register tag.
- out_valid  output  1  stage B holds a result.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  N  shifted result.
- out_tag  output  T  tag carried with out_data.
- out_zero  output  1  out_data == 0.
- out_err  output  1  result came from an illegal opcode.

Behaviour:
- Reset: a_valid=0, b_valid=0, out_valid=0, out_data=0, out_tag=0, out_zero=1, out_err=0. Reset overrides any handshake in the same cycle. An in-flight op is discarded when rst is asserted mid-operation.
- Advance and ready rules:
  - b_adv = ~b_valid | out_ready.
  - a_adv = ~a_valid | b_adv.
  - in_ready = a_adv; it is combinational from out_ready and has no path from in_valid.
- Stage A:
  - When in_valid & in_ready, capture opc, data, cnt, tag and set a_valid=1.
  - Otherwise, if b_adv, set a_valid=0.
  - Otherwise hold all stage A registers.
- Shifter mapping (combinational from stage A registers):
  - ROL: op 00, count cnt.
  - SLL: op 01, count cnt.
  - SRA: op 10, count cnt.
  - SRL: op 11, count cnt.
  - ROR: op 00, count (0 - cnt) mod 16, so ROR 0 = identity.
  - Illegal opcode: op 00, count 0 (result equals operand), and err flag set.
- Stage B: when b_adv, load out_data, out_tag, out_err and out_zero from stage A, and set b_valid=a_valid. Hold otherwise.
- Latency: accept at edge k, result visible after edge k+1 (out_valid high in cycle k+1). Throughput is 1 op/cycle when out_ready stays high.
- Stability: out_data, out_tag, out_zero and out_err are stable while out_valid & ~out_ready. No op is dropped or duplicated under any out_ready pattern.
- Simultaneous events: full pipe with out_ready=1 accepts a new op and drains B in the same cycle. Full pipe with out_ready=0 holds in_ready=0.
- out_zero and out_err are registered; they are meaningful only when out_valid=1.

Optional Feature:
- Macro SHIFT_ROR_EN.
- Defined: opcode 010 executes ROR as specified above.
- Undefined: 010 is treated as illegal (identity result, out_err=1). The count-negation logic is not compiled.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, out_zero=1, out_err=0.
- Basic ops, out_ready=1: in_data=16'h8421, cnt=4.
  - ROL -> 16'h4218.
  - SLL -> 16'h4210.
  - SRL -> 16'h0842.
  - SRA -> 16'hF842.
  - Each appears one cycle after accept, carrying its tag.
- ROR (SHIFT_ROR_EN defined): in_data=16'h0001, cnt=1 -> 16'h8000. cnt=0 -> 16'h0001. Without the macro -> 16'h0001 and out_err=1.
- Backpressure: issue 4 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepts and out_data holds steady. Release out_ready -> all 4 results emerge in order with no loss.
- Illegal opcode 111, in_data=16'h0000 -> out_data=16'h0000, out_zero=1, out_err=1. A following legal op -> out_err=0.
- Reset mid-flight: 2 ops in pipe, rst=1 for one cycle -> out_valid=0 next cycle and neither result ever appears.

Source files
------------

// File: rtl/shift_exec_pipe.sv
// rtl/shift_exec_pipe.sv - two-stage pipelined shift/rotate execute unit with tagged result
// Optional ROR support for opcode 010 is compiled in when SHIFT_ROR_EN is defined.

module barrelShifter #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic [N-1:0] data,
  input  logic [1:0]   op,
  input  logic [C-1:0] cnt,
  output logic [N-1:0] result
);

  logic [N-1:0] stage;

  // Log-depth network: stage i shifts by 2**i when cnt[i] is set.
  always_comb begin
    stage = data;
    for (int i = 0; i < C; i++) begin
      if (cnt[i]) begin
        case (op)
          2'b00:   stage = (stage << (1 << i)) | (stage >> (N - (1 << i)));
          2'b01:   stage = stage << (1 << i);
          2'b10:   stage = $signed(stage) >>> (1 << i);
          default: stage = stage >> (1 << i);
        endcase
      end
    end
    result = stage;
  end

endmodule

module shift_exec_pipe #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int T = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_opc,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [T-1:0] in_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [T-1:0] out_tag,
  output logic         out_zero,
  output logic         out_err
);

  logic         a_valid;
  logic [2:0]   a_opc;
  logic [N-1:0] a_data;
  logic [C-1:0] a_cnt;
  logic [T-1:0] a_tag;
  logic         b_valid;
  logic         b_adv;
  logic         a_adv;

  logic [1:0]   sh_op;
  logic [C-1:0] sh_cnt;
  logic         sh_illegal;
  logic [N-1:0] sh_result;

  assign b_adv     = ~b_valid | out_ready;
  assign a_adv     = ~a_valid | b_adv;
  assign in_ready  = a_adv;
  assign out_valid = b_valid;

  // Payload registers are cleared too so idle cycles after reset present zero/no-error.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_opc   <= 3'b000;
      a_data  <= '0;
      a_cnt   <= '0;
      a_tag   <= '0;
    end else if (in_valid && a_adv) begin
      a_valid <= 1'b1;
      a_opc   <= in_opc;
      a_data  <= in_data;
      a_cnt   <= in_cnt;
      a_tag   <= in_tag;
    end else if (b_adv) begin
      a_valid <= 1'b0;
    end
  end

  always_comb begin
    sh_op      = 2'b00;
    sh_cnt     = a_cnt;
    sh_illegal = 1'b0;
    case (a_opc)
      3'b000: sh_op = 2'b00;
      3'b001: sh_op = 2'b01;
      3'b011: sh_op = 2'b11;
      3'b100: sh_op = 2'b10;
`ifdef SHIFT_ROR_EN
      // Rotate right by k is rotate left by (-k) mod 2**C; k=0 stays identity.
      3'b010: begin
        sh_op  = 2'b00;
        sh_cnt = -a_cnt;
      end
`endif
      default: begin
        sh_op      = 2'b00;
        sh_cnt     = '0;
        sh_illegal = 1'b1;
      end
    endcase
  end

  barrelShifter #(.N(N), .C(C)) u_shifter (
    .data   (a_data),
    .op     (sh_op),
    .cnt    (sh_cnt),
    .result (sh_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid  <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_zero <= 1'b1;
      out_err  <= 1'b0;
    end else if (b_adv) begin
      b_valid  <= a_valid;
      out_data <= sh_result;
      out_tag  <= a_tag;
      out_zero <= (sh_result == '0);
      out_err  <= sh_illegal;
    end
  end

endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb/tb_shift_exec_pipe.sv - randomized and directed self-checking bench for shift_exec_pipe
// Reference model follows SHIFT_ROR_EN the same way the design does.

module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opc;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_tag;
  logic        out_zero;
  logic        out_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  t;
    logic        e;
  } exp_t;

  shift_exec_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opc    (in_opc),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] opc, input logic [15:0] d,
                                 input logic [3:0] c, input logic [2:0] t);
    exp_t r;
    logic [31:0] w;
    w = {d, d};
    r.t = t;
    r.e = 1'b0;
    case (opc)
      3'd0: begin w = w << c; r.d = w[31:16]; end
      3'd1: r.d = d << c;
      3'd3: r.d = d >> c;
      3'd4: r.d = $signed(d) >>> c;
`ifdef SHIFT_ROR_EN
      3'd2: begin w = w >> c; r.d = w[15:0]; end
`endif
      default: begin r.d = d; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] opc, input logic [15:0] d,
                       input logic [3:0] c, input logic [2:0] t);
    in_valid = 1'b1; in_opc = opc; in_data = d; in_cnt = c; in_tag = t;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b1 || out_err !== 1'b0 ||
        out_data !== 16'h0 || out_tag !== 3'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b zero=%b err=%b data=%h tag=%h expected 0 1 1 0 0000 0",
               out_valid, in_ready, out_zero, out_err, out_data, out_tag);
    end
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b1 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b ready=%b zero=%b err=%b expected 0 1 1 0",
               out_valid, in_ready, out_zero, out_err);
    end
  endtask

  task automatic run_one(input string name, input logic [2:0] opc, input logic [15:0] d,
                         input logic [3:0] c, input logic [2:0] t,
                         input logic [15:0] exp_d, input logic exp_e);
    drive(opc, d, c, t);
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: out_valid=%b expected 0 in accept cycle", name, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== t || out_err !== exp_e ||
        out_zero !== (exp_d == 16'h0)) begin
      failures++;
      $display("FAIL %s: valid=%b data=%h tag=%h err=%b zero=%b expected 1 %h %h %b %b",
               name, out_valid, out_data, out_tag, out_err, out_zero, exp_d, t, exp_e, exp_d == 16'h0);
    end
    cyc();
  endtask

  task automatic test_basic();
    do_reset();
    run_one("rol", 3'd0, 16'h8421, 4'd4, 3'd1, 16'h4218, 1'b0);
    run_one("sll", 3'd1, 16'h8421, 4'd4, 3'd2, 16'h4210, 1'b0);
    run_one("srl", 3'd3, 16'h8421, 4'd4, 3'd3, 16'h0842, 1'b0);
    run_one("sra", 3'd4, 16'h8421, 4'd4, 3'd4, 16'hF842, 1'b0);
  endtask

  task automatic test_ror();
    do_reset();
`ifdef SHIFT_ROR_EN
    run_one("ror1", 3'd2, 16'h0001, 4'd1, 3'd5, 16'h8000, 1'b0);
    run_one("ror0", 3'd2, 16'h0001, 4'd0, 3'd6, 16'h0001, 1'b0);
`else
    run_one("ror_off", 3'd2, 16'h0001, 4'd1, 3'd5, 16'h0001, 1'b1);
`endif
  endtask

  task automatic test_illegal();
    do_reset();
    run_one("illegal", 3'd7, 16'h0000, 4'd5, 3'd7, 16'h0000, 1'b1);
    run_one("after_illegal", 3'd1, 16'h0001, 4'd1, 3'd0, 16'h0002, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_t exp_q[$];
    int idx = 0;
    int got = 0;
    logic [15:0] held;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx < 4) drive(3'd1, 16'h0001 << idx, 4'd1, 3'(idx)); else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(3'd1, 16'h0001 << idx, 4'd1, 3'(idx)));
        idx++;
      end
      cyc();
      if (k == 2) held = out_data;
    end
    checks++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: accepts=%0d in_ready=%b expected 2 0", idx, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== held) begin
      failures++;
      $display("FAIL bp_hold: valid=%b data=%h expected 1 %h", out_valid, out_data, held);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got < 4; k++) begin
      if (idx < 4) drive(3'd1, 16'h0001 << idx, 4'd1, 3'(idx)); else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0].d || out_tag !== exp_q[0].t) begin
          failures++;
          $display("FAIL bp_order: data=%h tag=%h expected %h %h", out_data, out_tag,
                   exp_q.size() ? exp_q[0].d : 16'h0, exp_q.size() ? exp_q[0].t : 3'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(3'd1, 16'h0001 << idx, 4'd1, 3'(idx)));
        idx++;
      end
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL bp_count: results=%0d expected 4", got);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    do_reset();
    out_ready = 1'b0;
    drive(3'd0, 16'h1234, 4'd3, 3'd1);
    cyc();
    drive(3'd0, 16'h5678, 4'd3, 3'd2);
    cyc();
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_zero !== 1'b1) begin
      failures++;
      $display("FAIL midflight_reset: valid=%b zero=%b expected 0 1", out_valid, out_zero);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) seen++;
      cyc();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midflight_leak: results_seen=%0d expected 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic prev_hold = 1'b0;
    logic [15:0] p_d;
    logic [2:0] p_t;
    logic p_z, p_e;
    logic exp_ready;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k < 560) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_opc = 3'($urandom_range(0, 7));
      in_data = 16'($urandom);
      in_cnt = 4'($urandom_range(0, 15));
      in_tag = 3'($urandom_range(0, 7));
      #1;
      exp_ready = (q.size() < 2) || out_ready;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d: in_ready=%b expected %b", k, in_ready, exp_ready);
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== p_d || out_tag !== p_t || out_zero !== p_z ||
            out_err !== p_e) begin
          failures++;
          $display("FAIL rnd_stable cyc=%0d: valid=%b data=%h tag=%h expected 1 %h %h",
                   k, out_valid, out_data, out_tag, p_d, p_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious cyc=%0d: out_valid=1 with no op outstanding", k);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_tag !== e.t || out_err !== e.e || out_zero !== (e.d == 16'h0)) begin
            failures++;
            $display("FAIL rnd_result cyc=%0d: data=%h tag=%h err=%b zero=%b expected %h %h %b %b",
                     k, out_data, out_tag, out_err, out_zero, e.d, e.t, e.e, e.d == 16'h0);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_opc, in_data, in_cnt, in_tag));
      prev_hold = out_valid && !out_ready;
      p_d = out_data; p_t = out_tag; p_z = out_zero; p_e = out_err;
      cyc();
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: outstanding=%0d expected 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opc = 3'd0; in_data = 16'h0; in_cnt = 4'd0; in_tag = 3'd0;
    test_reset();
    test_basic();
    test_ror();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
